// File: rtl/rob_pkg.sv
// Shared ROB types: tag type, invalid-tag constant and entry record.
// ID, reservation stations and the register file import this package too.
package rob_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_TAG_W  = 4;
  localparam int ROB_OP_W   = 6;
  localparam int ROB_DATA_W = 32;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  localparam rob_tag_t TAG_INVALID = '1;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [4:0]            rd;
    logic [ROB_OP_W-1:0]   op;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  function automatic logic tag_is_valid(input rob_tag_t tag);
    return tag != TAG_INVALID;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear.
// Used for the ROB head and tail.
module rob_ptr #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr;
    if (clr)
      ptr_nxt = '0;
    else if (inc)
      ptr_nxt = (ptr == W'(DEPTH - 1)) ? '0 : ptr + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue tags, out-of-order CDB completion, in-order commit.
// Optional macro ROB_CDB_BYPASS_EN lets a CDB result on the head entry commit at the same edge.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_tag,
  input  logic              alloc_req,
  input  logic [4:0]        alloc_rd,
  input  logic [OP_W-1:0]   alloc_op,
  output logic [TAG_W-1:0]  avail_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              wb_en,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b1}};

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W-1:0]  count;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  done;
  logic [4:0]        rd_q   [DEPTH];
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;
  logic [IDX_W-1:0]  cdb_idx;
  logic              alloc_ok;
  logic              cdb_hit;
  logic              head_byp;
  logic              commit;
  logic [DATA_W-1:0] commit_data;

  assign head_idx  = head[IDX_W-1:0];
  assign tail_idx  = tail[IDX_W-1:0];
  assign cdb_idx   = cdb_tag[IDX_W-1:0];

  assign avail_tag = tail;
  assign full      = (count == TAG_W'(DEPTH));
  assign alloc_ok  = alloc_req && !full;

  // TAG_INVALID is always >= DEPTH, so the range check also filters it.
  assign cdb_hit   = cdb_valid && (cdb_tag < TAG_W'(DEPTH)) && busy[cdb_idx];

`ifdef ROB_CDB_BYPASS_EN
  assign head_byp  = cdb_hit && (cdb_tag == head);
`else
  assign head_byp  = 1'b0;
`endif

  assign commit      = (count != '0) && (done[head_idx] || head_byp);
  assign commit_data = done[head_idx] ? data_q[head_idx] : cdb_data;

  rob_ptr #(.DEPTH(DEPTH), .W(TAG_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (rst_tag),
    .inc (commit),
    .ptr (head)
  );

  rob_ptr #(.DEPTH(DEPTH), .W(TAG_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (rst_tag),
    .inc (alloc_ok),
    .ptr (tail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (rst_tag) begin
      count <= '0;
    end else begin
      case ({alloc_ok, commit})
        2'b10:   count <= count + TAG_W'(1);
        2'b01:   count <= count - TAG_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Allocation can only land on the head slot when full, where it is refused,
  // so alloc and commit never target the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      done <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        op_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (rst_tag) begin
      busy <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_ok && (tail_idx == IDX_W'(i))) begin
          busy[i] <= 1'b1;
          done[i] <= 1'b0;
          rd_q[i] <= alloc_rd;
          op_q[i] <= alloc_op;
        end
        if (cdb_hit && (cdb_idx == IDX_W'(i))) begin
          done[i]   <= 1'b1;
          data_q[i] <= cdb_data;
        end
        if (commit && (head_idx == IDX_W'(i))) begin
          busy[i] <= 1'b0;
          done[i] <= 1'b0;
        end
      end
    end
  end

  // wb_rd / wb_data hold their last committed values while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_tag  <= TAG_NONE;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (rst_tag) begin
      wb_en   <= 1'b0;
      wb_tag  <= TAG_NONE;
    end else if (commit) begin
      wb_en   <= 1'b1;
      wb_tag  <= head;
      wb_rd   <= rd_q[head_idx];
      wb_data <= commit_data;
    end else begin
      wb_en   <= 1'b0;
      wb_tag  <= TAG_NONE;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expectations follow ROB_CDB_BYPASS_EN when defined.
module tb_reorder_buffer;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_tag;
  logic        alloc_req;
  logic [4:0]  alloc_rd;
  logic [5:0]  alloc_op;
  logic [3:0]  avail_tag;
  logic        full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        wb_en;
  logic [3:0]  wb_tag;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(8), .TAG_W(4), .OP_W(6), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_tag   (rst_tag),
    .alloc_req (alloc_req),
    .alloc_rd  (alloc_rd),
    .alloc_op  (alloc_op),
    .avail_tag (avail_tag),
    .full      (full),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .wb_en     (wb_en),
    .wb_tag    (wb_tag),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [3:0] t, input logic [4:0] rd,
                            input logic [31:0] d);
    chk({tag, "_en"},   32'(wb_en),  32'd1);
    chk({tag, "_tag"},  32'(wb_tag), 32'(t));
    chk({tag, "_rd"},   32'(wb_rd),  32'(rd));
    chk({tag, "_data"}, wb_data,     d);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"},  32'(wb_en),  32'd0);
    chk({tag, "_tag"}, 32'(wb_tag), 32'hF);
  endtask

  initial begin
    rst = 1'b1; rst_tag = 1'b0; alloc_req = 1'b0; alloc_rd = '0; alloc_op = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_avail", 32'(avail_tag), 32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk_idle("rst_wb");
    chk("rst_wb_rd",   32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data,    32'd0);
    rst = 1'b0;
    step();

    // Fill: tags 0..7, rd = tag+1.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill_avail%0d", i), 32'(avail_tag), 32'(i));
      chk($sformatf("fill_full%0d", i),  32'(full),      32'd0);
      alloc_req = 1'b1; alloc_rd = 5'(i + 1); alloc_op = 6'(i);
      step();
    end
    chk("full_after8",  32'(full),      32'd1);
    chk("avail_after8", 32'(avail_tag), 32'd0);
    alloc_rd = 5'd20;
    step();
    chk("refuse9_full",  32'(full),      32'd1);
    chk("refuse9_avail", 32'(avail_tag), 32'd0);
    chk_idle("refuse9_wb");

    // Out-of-order completion while ID keeps requesting.
    alloc_rd = 5'd9;
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h22;
    step();
    chk_idle("cdb2_wb");
    chk("cdb2_full", 32'(full), 32'd1);
    cdb_tag = 4'd1; cdb_data = 32'h11;
    step();
    chk_idle("cdb1_wb");
    cdb_tag = 4'd0; cdb_data = 32'h00;
    step();
    cdb_valid = 1'b0;
    if (!BYP) begin
      chk_idle("cdb0_wb");
      chk("cdb0_full", 32'(full), 32'd1);
      step();
    end
    // Commit of tag 0 while full: the concurrent allocation was refused.
    chk_commit("c0", 4'd0, 5'd1, 32'h00);
    chk("c0_full",  32'(full),      32'd0);
    chk("c0_avail", 32'(avail_tag), 32'd0);
    step();
    chk_commit("c1", 4'd1, 5'd2, 32'h11);
    chk("wrap_avail", 32'(avail_tag), 32'd1);
    alloc_req = 1'b0;
    step();
    chk_commit("c2", 4'd2, 5'd3, 32'h22);
    step();
    chk_idle("c3_idle");
    chk("hold_rd",   32'(wb_rd), 32'd3);
    chk("hold_data", wb_data,    32'h22);

    // Ignored CDB: invalid tag, out-of-range tag, non-busy tag (1).
    cdb_valid = 1'b1; cdb_tag = 4'hF; cdb_data = 32'hDEAD;
    step();
    chk_idle("cdb_inv");
    cdb_tag = 4'd8;
    step();
    chk_idle("cdb_oor");
    cdb_tag = 4'd1; cdb_data = 32'hBEEF;
    step();
    chk_idle("cdb_notbusy");
    chk("notbusy_avail", 32'(avail_tag), 32'd1);

    // Head is tag 3 (rd 4).
    cdb_tag = 4'd3; cdb_data = 32'hAB;
    step();
    cdb_valid = 1'b0;
    if (BYP) begin
      chk_commit("byp3", 4'd3, 5'd4, 32'hAB);
    end else begin
      chk_idle("nobyp3_early");
      step();
      chk_commit("nobyp3", 4'd3, 5'd4, 32'hAB);
    end
    step();
    chk_idle("after3");

    // Five live entries (4..7, 0). Flush with concurrent completion and allocation.
    rst_tag = 1'b1; alloc_req = 1'b1; alloc_rd = 5'd7;
    cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_data = 32'h44;
    step();
    rst_tag = 1'b0; alloc_req = 1'b0; cdb_valid = 1'b0;
    chk("flush_avail", 32'(avail_tag), 32'd0);
    chk("flush_full",  32'(full),      32'd0);
    chk_idle("flush_wb");
    step();
    chk_idle("flush_lost");

    // Count restarted at zero: exactly 8 more allocations fill it.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("refill_full%0d", i), 32'(full), 32'd0);
      alloc_req = 1'b1; alloc_rd = 5'(10 + i);
      step();
    end
    alloc_req = 1'b0;
    chk("refill_full", 32'(full), 32'd1);
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h5A;
    step();
    cdb_valid = 1'b0;
    if (!BYP) begin
      chk_idle("refill_wait");
      step();
    end
    chk_commit("refill_c0", 4'd0, 5'd10, 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
